// File: rtl/onecold_pkg.sv
// Shared types and constants for the one-cold encoder slice.
package onecold_pkg;

    localparam int ONECOLD_W = 8;
    localparam int CODE_W    = 3;

    // An all-ones vector selects nothing; it reports the top code with an error.
    localparam logic [ONECOLD_W-1:0] ALL_ONES_VEC = '1;
    localparam logic [CODE_W-1:0]    NONE_CODE    = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/onecold_encoder_if.sv
// Valid/ready bundle between producer, encoder and consumer.
interface onecold_encoder_if;
    import onecold_pkg::*;

    logic [ONECOLD_W-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [CODE_W-1:0]    out_code;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_code, out_err, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_code, out_err, out_valid
    );

endinterface

// File: rtl/onecold_prio_enc.sv
// Combinational one-cold priority encoder: lowest low bit wins, err unless exactly one low bit.
module onecold_prio_enc
    import onecold_pkg::*;
(
    input  logic [ONECOLD_W-1:0] in_data,
    output logic [CODE_W-1:0]    code,
    output logic                 err
);

    logic [3:0] n_low;

    always_comb begin
        code  = NONE_CODE;
        n_low = 4'd0;
        // Scan downward so the lowest low bit is the last (winning) assignment.
        for (int i = ONECOLD_W - 1; i >= 0; i--) begin
            if (!in_data[i]) begin
                code  = CODE_W'(i);
                n_low = n_low + 4'd1;
            end
        end
    end

    assign err = (in_data == ALL_ONES_VEC) | (n_low > 4'd1);

endmodule

// File: rtl/onecold_encoder.sv
// One-cold to binary encoder with a single output register stage.
// Optional saturating error counter enabled by ONECOLD_ENC_ERRCNT_EN.
//
//   state  | meaning
//   EMPTY  | output register holds nothing, out_valid=0
//   FULL   | output register holds a result, out_valid=1
module onecold_encoder
    import onecold_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    onecold_encoder_if.slave   bus
`ifdef ONECOLD_ENC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]   err_cnt
`endif
);

    localparam logic [0:0] S_EMPTY = 1'(EMPTY);
    localparam logic [0:0] S_FULL  = 1'(FULL);

    logic [0:0]        state;
    logic [CODE_W-1:0] code_q;
    logic              err_q;
    logic [CODE_W-1:0] enc_code;
    logic              enc_err;
    logic              in_hs;
    logic              out_hs;

    onecold_prio_enc u_prio_enc (
        .in_data (bus.in_data),
        .code    (enc_code),
        .err     (enc_err)
    );

    assign bus.in_ready  = (state == S_EMPTY) | bus.out_ready;
    assign bus.out_valid = (state == S_FULL);
    assign bus.out_code  = code_q;
    assign bus.out_err   = err_q;

    assign in_hs  = bus.in_valid & bus.in_ready;
    assign out_hs = bus.out_valid & bus.out_ready;

    // A simultaneous in/out handshake keeps the stage FULL with fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_EMPTY;
            code_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (in_hs) begin
                state  <= S_FULL;
                code_q <= enc_code;
                err_q  <= enc_err;
            end else if (out_hs) begin
                state  <= S_EMPTY;
            end
        end
    end

`ifdef ONECOLD_ENC_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (in_hs && enc_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
